// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the E stage; owns the HI/LO registers.
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   reset  - asynchronous, active-high reset
//   md_op  - operation issued from E: 0 none, 1 mult, 2 multu, 3 div,
//            4 divu, 5 mthi, 6 mtlo, 7 reserved (none)
//   A, B   - forwarded rs / rt operands, sampled only at the issue edge
//   busy   - operation in flight, HI/LO not yet updated
//   start  - combinational, an md op is issued this cycle
//   HI, LO - architectural HI/LO registers, read directly by mfhi/mflo
//
// Parameters:
//   MULT_CYCLES - busy cycles for mult/multu (1..15)
//   DIV_CYCLES  - busy cycles for div/divu (1..15)
//
// Build option:
//   MD_DIV0_HOLD_EN - when defined, div/divu by zero still take the full
//                     latency but leave HI/LO unchanged at completion.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        start,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   pend_hi_q, pend_lo_q;
  logic                issue_c;
  logic                done_c;
  logic                is_div_c;
  logic                div0_c;

  // Arithmetic datapath signals
  logic [63:0]         prod_s_c, prod_u_c;
  logic                a_neg_c, b_neg_c;
  logic [DATA_W-1:0]   a_mag_c, b_mag_c, b_safe_c;
  logic [DATA_W-1:0]   q_mag_c, r_mag_c, quot_c, rem_c;
  logic [DATA_W-1:0]   res_hi_c, res_lo_c;

`ifdef MD_DIV0_HOLD_EN
  logic                pend_keep_q;
`endif

  // busy is the state flop itself
  assign busy     = (state_q == S_BUSY);
  assign is_div_c = (md_op == OP_DIV) || (md_op == OP_DIVU);
  assign div0_c   = is_div_c && (B == '0);
  assign start    = issue_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state, issue and completion decode
  always_comb begin
    state_d = state_q;
    issue_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (md_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
          issue_c = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // cnt of 0 cannot occur with legal parameters; treat it as done anyway
        if (cnt_q <= CNT_W'(1)) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Products: sign-extended operands give the signed product in the low 64 bits
  assign prod_s_c = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u_c = {32'd0, A} * {32'd0, B};

  // Division on magnitudes, then re-apply signs; avoids the signed overflow case
  assign a_neg_c  = (md_op == OP_DIV) && A[31];
  assign b_neg_c  = (md_op == OP_DIV) && B[31];
  assign a_mag_c  = a_neg_c ? DATA_W'(~A + 32'd1) : A;
  assign b_mag_c  = b_neg_c ? DATA_W'(~B + 32'd1) : B;
  assign b_safe_c = (b_mag_c == '0) ? DATA_W'(1) : b_mag_c;
  assign q_mag_c  = a_mag_c / b_safe_c;
  assign r_mag_c  = a_mag_c % b_safe_c;
  assign quot_c   = (a_neg_c ^ b_neg_c) ? DATA_W'(~q_mag_c + 32'd1) : q_mag_c;
  assign rem_c    = a_neg_c ? DATA_W'(~r_mag_c + 32'd1) : r_mag_c;

  // Result selection for the issuing op
  always_comb begin
    res_hi_c = '0;
    res_lo_c = '0;
    case (md_op)
      OP_MULT:  {res_hi_c, res_lo_c} = prod_s_c;
      OP_MULTU: {res_hi_c, res_lo_c} = prod_u_c;
      OP_DIV, OP_DIVU: begin
        if (div0_c) begin
          res_hi_c = A;
          res_lo_c = '1;
        end else begin
          res_hi_c = rem_c;
          res_lo_c = quot_c;
        end
      end
      default: begin
        res_hi_c = '0;
        res_lo_c = '0;
      end
    endcase
  end

  // Pending result, latency counter and HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      HI          <= '0;
      LO          <= '0;
`ifdef MD_DIV0_HOLD_EN
      pend_keep_q <= 1'b0;
`endif
    end else if (issue_c) begin
      pend_hi_q   <= res_hi_c;
      pend_lo_q   <= res_lo_c;
      cnt_q       <= is_div_c ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
`ifdef MD_DIV0_HOLD_EN
      pend_keep_q <= div0_c;
`endif
    end else if (state_q == S_BUSY) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (done_c) begin
`ifdef MD_DIV0_HOLD_EN
        if (!pend_keep_q) begin
          HI <= pend_hi_q;
          LO <= pend_lo_q;
        end
`else
        HI <= pend_hi_q;
        LO <= pend_lo_q;
`endif
      end
    end else begin
      // Moves to HI/LO only land while idle
      if (md_op == OP_MTHI) HI <= A;
      if (md_op == OP_MTLO) LO <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed checks of md_unit timing, arithmetic, ignored ops and reset.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        busy, start;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  int n;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk  (clk),
    .reset(reset),
    .md_op(md_op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .start(start),
    .HI   (HI),
    .LO   (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count cycles for which busy stays high, bounded
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
  endtask

  // Issue one md op, scramble operands during busy, check latency and HI/LO
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int c;
    md_op = op; A = a; B = b;
    #1;
    chk({tag, "_start"}, {31'd0, start}, 32'd1);
    step();
    md_op = 3'd0; A = 32'hA5A5_5A5A; B = 32'h0000_0003;
    count_busy(c);
    chk({tag, "_lat"}, 32'(c), 32'(lat));
    chk({tag, "_hi"}, HI, ehi);
    chk({tag, "_lo"}, LO, elo);
  endtask

  initial begin
    reset = 1'b1; md_op = 3'd0; A = '0; B = '0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_start", {31'd0, start}, 32'd0);
    chk("idle_hi", HI, 32'd0);

    run_op("mult",   3'd1, 32'hFFFF_FFFE, 32'd3, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu",  3'd2, 32'hFFFF_FFFE, 32'd3, 5,  32'h0000_0002, 32'hFFFF_FFFA);
    run_op("mult_nn",3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 5, 32'h0, 32'h0000_000F);
    run_op("div",    3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",   3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("div_ovf",3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

    // mthi while idle
    md_op = 3'd5; A = 32'h1234_5678;
    #1;
    chk("mthi_start", {31'd0, start}, 32'd0);
    step();
    md_op = 3'd0;
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_lo", LO, 32'h8000_0000);
    chk("mthi_busy", {31'd0, busy}, 32'd0);

    // mult with an mtlo and a second mult dropped during busy
    md_op = 3'd1; A = 32'h0001_0000; B = 32'h0001_0000;
    #1;
    chk("ign_start", {31'd0, start}, 32'd1);
    step();
    md_op = 3'd6; A = 32'h0000_DEAD;
    #1;
    chk("ign_mtlo_start", {31'd0, start}, 32'd0);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    step();
    md_op = 3'd1; A = 32'd1; B = 32'd1;
    #1;
    chk("ign_mult_start", {31'd0, start}, 32'd0);
    step();
    md_op = 3'd0;
    count_busy(n);
    chk("ign_lat_rest", 32'(n), 32'd3);
    chk("ign_hi", HI, 32'd1);
    chk("ign_lo", LO, 32'd0);

    // divide by zero with known HI/LO
    md_op = 3'd5; A = 32'h11;
    step();
    md_op = 3'd6; A = 32'h22;
    step();
    md_op = 3'd0;
    chk("pre_div0_hi", HI, 32'h11);
    chk("pre_div0_lo", LO, 32'h22);
`ifdef MD_DIV0_HOLD_EN
    run_op("divu0", 3'd4, 32'h55, 32'd0, 10, 32'h11, 32'h22);
`else
    run_op("divu0", 3'd4, 32'h55, 32'd0, 10, 32'h55, 32'hFFFF_FFFF);
`endif

    // reset in the middle of an operation
    md_op = 3'd1; A = 32'd6; B = 32'd7;
    step();
    md_op = 3'd0;
    step();
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_hi", HI, 32'd0);
    chk("mid_rst_lo", LO, 32'd0);
    step();
    reset = 1'b0;
    step();
    step();
    step();
    step();
    step();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_lo", LO, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
